// File: rtl/logic_ex_debounced.sv
// Debounced switch bank driving registered gate-reduction LEDs, with a change pulse
// and a wrapping 8-bit count of accepted debounced changes.
module logic_ex_debounced #(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] SW,
    output logic [3:0]        LED,
    output logic              chg,
    output logic [7:0]        chg_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // A differing sample seen while the counter holds this value completes the run.
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [NUM_SW-1:0] db;
    logic [NUM_SW-1:0] db_next;
    logic [CW-1:0]     cnt      [NUM_SW];
    logic [CW-1:0]     cnt_next [NUM_SW];
    logic              any_change;

    always_comb begin
        db_next = db;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != db[i]) begin
                if (cnt[i] == LAST_CNT) begin
                    db_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    assign any_change = |(db_next ^ db);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                cnt[i] <= '0;
            end
            LED       <= 4'b0001;
            chg       <= 1'b0;
            chg_count <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            db    <= db_next;
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                cnt[i] <= cnt_next[i];
            end
            LED       <= {^db, |db, &db, ~db[0]};
            chg       <= any_change;
            chg_count <= chg_count + {7'b0, any_change};
        end
    end

endmodule

// File: tb/tb_logic_ex_debounced.sv
// Randomized and directed checks of logic_ex_debounced against a sliding-window
// reference model of the debounce rule.
module tb_logic_ex_debounced;

    localparam int NW = 2;
    localparam int DB = 4;

    logic          clk;
    logic          rst;
    logic [NW-1:0] sw;
    logic [3:0]    led;
    logic          chg;
    logic [7:0]    chg_count;

    logic [3:0]    sw_w;
    logic [3:0]    led_w;
    logic          chg_w;
    logic [7:0]    cnt_w;

    int n_cmp = 0;
    int n_err = 0;

    logic_ex_debounced #(.NUM_SW(NW), .DEBOUNCE_CYCLES(DB)) u_dut (
        .clk(clk), .rst(rst), .SW(sw), .LED(led), .chg(chg), .chg_count(chg_count)
    );

    logic_ex_debounced #(.NUM_SW(4), .DEBOUNCE_CYCLES(DB)) u_wide (
        .clk(clk), .rst(rst), .SW(sw_w), .LED(led_w), .chg(chg_w), .chg_count(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a debounced bit flips once the last DB pre-edge synchronized samples all differ from it.
    logic [NW-1:0] p1, p2, m_db;
    logic [NW-1:0] hist [0:DB-2];
    logic [3:0]    m_led;
    logic          m_chg;
    logic [7:0]    m_cnt;

    function automatic logic [NW-1:0] accepted();
        logic [NW-1:0] nd;
        bit all_diff;
        nd = m_db;
        for (int b = 0; b < NW; b++) begin
            all_diff = (p2[b] != m_db[b]);
            for (int i = 0; i < DB - 1; i++)
                if (hist[i][b] == m_db[b]) all_diff = 0;
            if (all_diff) nd[b] = ~m_db[b];
        end
        return nd;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            p1 <= '0; p2 <= '0; m_db <= '0;
            for (int i = 0; i < DB - 1; i++) hist[i] <= '0;
            m_led <= 4'b0001; m_chg <= 1'b0; m_cnt <= 8'd0;
        end else begin
            hist[0] <= p2;
            for (int i = 1; i < DB - 1; i++) hist[i] <= hist[i-1];
            m_chg <= (accepted() != m_db);
            m_cnt <= m_cnt + ((accepted() != m_db) ? 8'd1 : 8'd0);
            m_led <= {^m_db, |m_db, &m_db, ~m_db[0]};
            m_db  <= accepted();
            p2 <= p1;
            p1 <= sw;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        sw = '0; sw_w = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        sw = '1; sw_w = '1; rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) rst = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({led, chg, chg_count} !== {4'b0001, 1'b0, 8'd0}) begin
                n_err++;
                $display("FAIL reset c%0d: got led=%b chg=%b cnt=%0d, want led=0001 chg=0 cnt=0", c, led, chg, chg_count);
            end
        end
    endtask

    task automatic test_latency();
        logic [3:0] e_led;
        do_reset();
        sw = 2'b01;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_led = (e >= 7) ? 4'b1100 : 4'b0001;
            n_cmp++;
            if ({led, chg, chg_count} !== {e_led, (e == 6), ((e >= 6) ? 8'd1 : 8'd0)}) begin
                n_err++;
                $display("FAIL latency e%0d: got led=%b chg=%b cnt=%0d, want led=%b chg=%b cnt=%0d",
                         e, led, chg, chg_count, e_led, (e == 6), (e >= 6) ? 1 : 0);
            end
            n_cmp++;
            if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                n_err++;
                $display("FAIL latency_model e%0d: got %b/%b/%0d, want %b/%b/%0d", e, led, chg, chg_count, m_led, m_chg, m_cnt);
            end
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] tt [4];
        tt[0] = 4'b0001; tt[1] = 4'b1100; tt[2] = 4'b1101; tt[3] = 4'b0110;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            sw = NW'(p);
            repeat (20) begin
                @(negedge clk);
                n_cmp++;
                if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                    n_err++;
                    $display("FAIL truth_model sw=%b: got %b/%b/%0d, want %b/%b/%0d", sw, led, chg, chg_count, m_led, m_chg, m_cnt);
                end
            end
            n_cmp++;
            if (led !== tt[p]) begin
                n_err++;
                $display("FAIL truth sw=%b: got led=%b, want %b", sw, led, tt[p]);
            end
        end
        n_cmp++;
        if (chg_count !== 8'd3) begin
            n_err++;
            $display("FAIL truth_count: got %0d, want 3", chg_count);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        do_reset();
        pulses = 0;
        for (int c = 0; c < 13; c++) begin
            sw = (c < 3) ? 2'b11 : 2'b00;
            @(negedge clk);
            pulses += int'(chg);
            n_cmp++;
            if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                n_err++;
                $display("FAIL bounce_short c%0d: got %b/%b/%0d, want %b/%b/%0d", c, led, chg, chg_count, m_led, m_chg, m_cnt);
            end
        end
        n_cmp++;
        if (pulses != 0 || led !== 4'b0001) begin
            n_err++;
            $display("FAIL bounce_short_end: got pulses=%0d led=%b, want pulses=0 led=0001", pulses, led);
        end
        pulses = 0;
        for (int c = 0; c < 70; c++) begin
            sw = (c < 50) ? {1'b0, ~sw[0]} : 2'b01;
            @(negedge clk);
            pulses += int'(chg);
            n_cmp++;
            if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                n_err++;
                $display("FAIL bounce_toggle c%0d: got %b/%b/%0d, want %b/%b/%0d", c, led, chg, chg_count, m_led, m_chg, m_cnt);
            end
        end
        n_cmp++;
        if (pulses != 1 || led !== 4'b1100) begin
            n_err++;
            $display("FAIL bounce_toggle_end: got pulses=%0d led=%b, want pulses=1 led=1100", pulses, led);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] e_led;
        do_reset();
        sw = 2'b11;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            e_led = (e >= 7) ? 4'b0110 : 4'b0001;
            n_cmp++;
            if ({led, chg, chg_count} !== {e_led, (e == 6), ((e >= 6) ? 8'd1 : 8'd0)}) begin
                n_err++;
                $display("FAIL mid_reset e%0d: got led=%b chg=%b cnt=%0d, want led=%b chg=%b cnt=%0d",
                         e, led, chg, chg_count, e_led, (e == 6), (e >= 6) ? 1 : 0);
            end
            n_cmp++;
            if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                n_err++;
                $display("FAIL mid_reset_model e%0d: got %b/%b/%0d, want %b/%b/%0d", e, led, chg, chg_count, m_led, m_chg, m_cnt);
            end
        end
    endtask

    task automatic test_wide();
        do_reset();
        sw_w = 4'b0111;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({led_w, cnt_w} !== {4'b1100, 8'd1}) begin
            n_err++;
            $display("FAIL wide_0111: got led=%b cnt=%0d, want led=1100 cnt=1", led_w, cnt_w);
        end
        sw_w = 4'b1111;
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({led_w, cnt_w} !== {4'b0110, 8'd2}) begin
            n_err++;
            $display("FAIL wide_1111: got led=%b cnt=%0d, want led=0110 cnt=2", led_w, cnt_w);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int c = 0; c < 500; c++) begin
            if (hold == 0) begin
                sw = NW'($urandom);
                hold = $urandom_range(1, 8);
            end
            hold--;
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            n_cmp++;
            if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                n_err++;
                $display("FAIL random c%0d: got %b/%b/%0d, want %b/%b/%0d", c, led, chg, chg_count, m_led, m_chg, m_cnt);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 256; n++) begin
            sw = (n % 2 == 0) ? 2'b01 : 2'b00;
            repeat (8) begin
                @(negedge clk);
                n_cmp++;
                if ({led, chg, chg_count} !== {m_led, m_chg, m_cnt}) begin
                    n_err++;
                    $display("FAIL wrap_model n%0d: got %b/%b/%0d, want %b/%b/%0d", n, led, chg, chg_count, m_led, m_chg, m_cnt);
                end
            end
            if (n == 254) begin
                n_cmp++;
                if (chg_count !== 8'd255) begin
                    n_err++;
                    $display("FAIL wrap_255: got %0d, want 255", chg_count);
                end
            end
        end
        n_cmp++;
        if (chg_count !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_0: got %0d, want 0", chg_count);
        end
    endtask

    initial begin
        rst = 1'b1; sw = '0; sw_w = '0;
        test_reset();
        test_latency();
        test_truth_table();
        test_bounce();
        test_mid_reset();
        test_wide();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
